// File: rtl/irq_injector.sv
// PC-triggered interrupt injector: steps through a trigger table and raises
// level (store-acknowledged) or fixed-width pulse interrupts on PC matches.
module irq_injector #(
  parameter int unsigned NUM_TRIG = 4,
  parameter int unsigned NUM_IRQ  = 6,
  parameter int unsigned PULSE_W  = 4,
  parameter logic [31:0] ACK_BASE = 32'h7F20,
  localparam int unsigned TW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1,
  localparam int unsigned LW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_we,
  input  logic [TW-1:0]      cfg_idx,
  input  logic               cfg_valid,
  input  logic               cfg_mode,
  input  logic [LW-1:0]      cfg_line,
  input  logic [31:0]        cfg_pc,
  input  logic [31:0]        macroscopic_pc,
  input  logic [31:0]        m_data_addr,
  input  logic [3:0]         m_data_byteen,
  output logic [NUM_IRQ-1:0] irq,
  output logic               running,
  output logic               done,
  output logic [TW-1:0]      trig_ptr
);
  localparam int unsigned CW        = 8;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic          valid;
    logic          mode;
    logic [LW-1:0] line;
    logic [31:0]   pc;
  } entry_t;

  state_e             state_q, state_d;
  logic [TW-1:0]      ptr_q, ptr_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pulse_q, pulse_d;
  logic [CW-1:0]      cnt_q [NUM_IRQ];
  logic [CW-1:0]      cnt_d [NUM_IRQ];
  entry_t             tbl_q [NUM_TRIG];
  entry_t             tbl_d [NUM_TRIG];
  logic               running_q, done_q;

  entry_t             cur;
  logic [NUM_IRQ-1:0] cur_sel;
  logic [NUM_IRQ-1:0] ack_hit;
  logic               pc_match;
  logic               fire;

  assign cur      = tbl_q[ptr_q];
  assign pc_match = (macroscopic_pc & ADDR_MASK) == (cur.pc & ADDR_MASK);

  // Per-line decode of the current entry's target and of acknowledge stores
  always_comb begin
    for (int k = 0; k < NUM_IRQ; k++) begin
      cur_sel[k] = (cur.line == LW'(k));
      ack_hit[k] = (|m_data_byteen) &&
                   ((m_data_addr & ADDR_MASK) == ((ACK_BASE + 32'(4 * k)) & ADDR_MASK));
    end
  end

  // Next-state: table writes, line retirement, sequencing and firing
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    irq_d   = irq_q;
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    fire    = 1'b0;

    for (int i = 0; i < NUM_TRIG; i++) begin
      if (cfg_we && (cfg_idx == TW'(i))) begin
        tbl_d[i].valid = cfg_valid && (32'(cfg_line) < NUM_IRQ);
        tbl_d[i].mode  = cfg_mode;
        tbl_d[i].line  = cfg_line;
        tbl_d[i].pc    = cfg_pc;
      end
    end

    // Pulse lines count down and ignore acks; level lines wait for their ack store
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (irq_q[k]) begin
        if (pulse_q[k]) begin
          if (cnt_q[k] == '0) begin
            irq_d[k] = 1'b0;
          end else begin
            cnt_d[k] = cnt_q[k] - CW'(1);
          end
        end else if (ack_hit[k]) begin
          irq_d[k] = 1'b0;
        end
      end
    end

    if (start) begin
      state_d = RUN;
      ptr_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (!cur.valid) begin
            state_d = DONE;
          end else if (pc_match && !(|(irq_q & cur_sel))) begin
            fire = 1'b1;
            if (ptr_q == TW'(NUM_TRIG - 1)) begin
              state_d = DONE;
            end else begin
              ptr_d = ptr_q + TW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    if (fire) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        if (cur_sel[k]) begin
          irq_d[k]   = 1'b1;
          pulse_d[k] = cur.mode;
          cnt_d[k]   = CW'(PULSE_W - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      irq_q     <= '0;
      pulse_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < NUM_IRQ; k++) cnt_q[k] <= '0;
      for (int i = 0; i < NUM_TRIG; i++) tbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      irq_q     <= irq_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      tbl_q     <= tbl_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign irq      = irq_q;
  assign running  = running_q;
  assign done     = done_q;
  assign trig_ptr = ptr_q;
endmodule

// File: tb/tb_irq_injector.sv
// Scoreboard bench for irq_injector: per-cycle expectations are queued as
// stimulus is driven and compared after the following clock edge.
module tb_irq_injector;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_valid;
  logic        cfg_mode;
  logic [2:0]  cfg_line;
  logic [31:0] cfg_pc;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [5:0]  irq;
  logic        running;
  logic        done;
  logic [1:0]  trig_ptr;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [5:0] irq;
    logic [1:0] ptr;
    logic       running;
    logic       done;
  } obs_t;

  obs_t sb_q[$];

  irq_injector dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_line(cfg_line), .cfg_pc(cfg_pc),
    .macroscopic_pc(macroscopic_pc), .m_data_addr(m_data_addr),
    .m_data_byteen(m_data_byteen), .irq(irq), .running(running), .done(done),
    .trig_ptr(trig_ptr)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.irq     = irq;
    o.ptr     = trig_ptr;
    o.running = running;
    o.done    = done;
    return o;
  endfunction

  function automatic obs_t mk(input logic [5:0] i, input int p, input bit r, input bit d);
    obs_t o;
    o.irq     = i;
    o.ptr     = 2'(p);
    o.running = r;
    o.done    = d;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
    cfg_mode = 1'b0; cfg_line = '0; cfg_pc = '0; macroscopic_pc = '0;
    m_data_addr = '0; m_data_byteen = '0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic write_entry(input int idx, input bit v, input bit m, input int line,
                             input logic [31:0] pc);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_valid = v; cfg_mode = m;
    cfg_line = 3'(line); cfg_pc = pc;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    macroscopic_pc = 32'h0; m_data_byteen = '0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, got;
    do_reset();
    sb_q.push_back(mk(6'b0, 0, 1'b0, 1'b0));
    got = observe(); e = sb_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_state got=%b exp=%b", got, e); end
    // Empty table: start runs, then invalid entry 0 ends the sequence
    for (int t = 0; t < 3; t++) begin
      start = (t == 0);
      sb_q.push_back(t == 0 ? mk(6'b0, 0, 1'b1, 1'b0) : mk(6'b0, 0, 1'b0, 1'b1));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL reset_empty_start t=%0d got=%b exp=%b", t, got, e); end
    end
    start = 1'b0;
  endtask

  task automatic test_level_walk();
    obs_t e, got;
    logic [5:0] ei;
    int ep;
    do_reset();
    write_entry(0, 1, 0, 0, 32'h3010);
    write_entry(1, 1, 0, 0, 32'h3038);
    write_entry(2, 1, 0, 0, 32'h3054);
    do_start();
    for (int t = 0; t < 26; t++) begin
      macroscopic_pc = 32'h3000 + 32'(4 * t);
      m_data_addr    = 32'h7F20;
      m_data_byteen  = (t == 6 || t == 16 || t == 23) ? 4'hF : 4'h0;
      ei = ((t >= 4 && t <= 5) || (t >= 14 && t <= 15) || (t >= 21 && t <= 22)) ? 6'b000001 : 6'b0;
      ep = (t < 4) ? 0 : (t < 14) ? 1 : (t < 21) ? 2 : 3;
      sb_q.push_back(mk(ei, ep, t < 22, t >= 22));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL level_walk t=%0d got=%b exp=%b", t, got, e); end
    end
  endtask

  task automatic test_pulse();
    obs_t e, got;
    do_reset();
    write_entry(0, 1, 1, 2, 32'h3010);
    do_start();
    for (int t = 0; t < 8; t++) begin
      macroscopic_pc = 32'h3010;
      m_data_addr    = 32'h7F28;
      m_data_byteen  = (t == 1 || t == 2) ? 4'hF : 4'h0;
      sb_q.push_back(mk(t <= 3 ? 6'b000100 : 6'b0, 1, t == 0, t >= 1));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL pulse t=%0d got=%b exp=%b", t, got, e); end
    end
  endtask

  task automatic test_stall_ack();
    obs_t e, got;
    logic [5:0] ei;
    do_reset();
    write_entry(0, 1, 0, 0, 32'h3010);
    write_entry(1, 1, 0, 0, 32'h3010);
    do_start();
    for (int t = 0; t < 11; t++) begin
      macroscopic_pc = 32'h3010;
      m_data_addr    = (t == 3) ? 32'h7F24 : 32'h7F20;
      m_data_byteen  = (t == 3 || t == 5 || t == 9) ? 4'hF : 4'h0;
      ei = (t <= 4 || (t >= 6 && t <= 8)) ? 6'b000001 : 6'b0;
      sb_q.push_back(mk(ei, t < 6 ? 1 : 2, t < 7, t >= 7));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL stall_ack t=%0d got=%b exp=%b", t, got, e); end
    end
  endtask

  task automatic test_invalid_line();
    obs_t e, got;
    do_reset();
    write_entry(0, 1, 0, 3, 32'h3020);
    write_entry(1, 1, 0, 7, 32'h3020);
    do_start();
    for (int t = 0; t < 7; t++) begin
      macroscopic_pc = 32'h3022;
      m_data_addr    = 32'h7F2C;
      m_data_byteen  = (t == 5) ? 4'h1 : 4'h0;
      sb_q.push_back(mk(t <= 4 ? 6'b001000 : 6'b0, 1, t == 0, t >= 1));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL invalid_line t=%0d got=%b exp=%b", t, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, got;
    logic [5:0] exp_irq [7];
    exp_irq = '{6'b000010, 6'b010010, 6'b110000, 6'b110000, 6'b110000, 6'b100000, 6'b100000};
    do_reset();
    write_entry(0, 1, 0, 1, 32'h4000);
    write_entry(1, 1, 1, 4, 32'h4004);
    write_entry(2, 1, 0, 5, 32'h4008);
    do_start();
    for (int t = 0; t < 7; t++) begin
      macroscopic_pc = (t < 3) ? 32'h4000 + 32'(4 * t) : 32'h4100;
      m_data_addr    = 32'h7F24;
      m_data_byteen  = (t == 2) ? 4'hF : 4'h0;
      sb_q.push_back(mk(exp_irq[t], t < 3 ? t + 1 : 3, t <= 2, t >= 3));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL back_to_back t=%0d got=%b exp=%b", t, got, e); end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, got;
    do_reset();
    write_entry(0, 1, 0, 0, 32'h3010);
    write_entry(1, 1, 0, 2, 32'h3014);
    do_start();
    for (int t = 0; t < 2; t++) begin
      macroscopic_pc = (t == 0) ? 32'h3010 : 32'h3014;
      sb_q.push_back(t == 0 ? mk(6'b000001, 1, 1'b1, 1'b0) : mk(6'b000101, 2, 1'b1, 1'b0));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL async_setup t=%0d got=%b exp=%b", t, got, e); end
    end
    // Reset pulse entirely between clock edges
    #2;
    reset = 1'b1;
    sb_q.push_back(mk(6'b0, 0, 1'b0, 1'b0));
    #1;
    got = observe(); e = sb_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL async_reset_drop got=%b exp=%b", got, e); end
    reset = 1'b0;
    // Table must be cleared: start with a PC that entry 0 used to match
    macroscopic_pc = 32'h3010;
    for (int t = 0; t < 2; t++) begin
      start = (t == 0);
      sb_q.push_back(t == 0 ? mk(6'b0, 0, 1'b1, 1'b0) : mk(6'b0, 0, 1'b0, 1'b1));
      step();
      got = observe(); e = sb_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL async_restart t=%0d got=%b exp=%b", t, got, e); end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level_walk();
    test_pulse();
    test_stall_ack();
    test_invalid_line();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/irq_injector.md
IRQ_INJECTOR -- requirements
Module: irq_injector

Interface
REQ-001 Parameter NUM_TRIG, default 4, SHALL set the number of trigger-table entries (≥2).
REQ-002 Parameter NUM_IRQ, default 6, SHALL set the number of interrupt lines (≥1).
REQ-003 Parameter PULSE_W, default 4, SHALL set the pulse-mode assertion length in cycles (1..255).
REQ-004 Parameter ACK_BASE, default 32'h7F20, SHALL set the word address whose store acknowledges line 0; line k acks at ACK_BASE+4k.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 start  in  1  one-cycle pulse; rewinds the pointer to 0 and begins sequencing.
REQ-008 cfg_we  in  1  trigger-table write strobe.
REQ-009 cfg_idx  in  clog2(NUM_TRIG)  entry to write.
REQ-010 cfg_valid / cfg_mode  in  1 / 1  entry valid; mode 0 = level-until-ack, 1 = pulse.
REQ-011 cfg_line  in  clog2(NUM_IRQ)  target line; values ≥NUM_IRQ SHALL make the entry invalid.
REQ-012 cfg_pc  in  32  trigger PC; bits [1:0] ignored.
REQ-013 macroscopic_pc  in  32  CPU PC, compared with bits [1:0] masked.
REQ-014 m_data_addr / m_data_byteen  in  32 / 4  CPU data-bus store address and byte enables.
REQ-015 irq  out  NUM_IRQ  registered interrupt lines.
REQ-016 running / done  out  1 / 1  sequencing active; sequence finished.
REQ-017 trig_ptr  out  clog2(NUM_TRIG)  current table entry.

Function
REQ-018 Table writes SHALL take effect in the cycle after cfg_we; a write to entry trig_ptr while running SHALL be used for that entry's next comparison.
REQ-019 States SHALL be IDLE, RUN, DONE; start from any state SHALL go to RUN with trig_ptr=0, done=0, irq unchanged.
REQ-020 In RUN, an invalid current entry SHALL move to DONE next cycle without asserting irq.
REQ-021 In RUN, fire SHALL occur when entry valid, (macroscopic_pc & ~3) == (cfg_pc & ~3), and irq[line]==0 in the current cycle.
REQ-022 On fire, irq[line] SHALL be 1 from the next posedge (latency 1); trig_ptr SHALL increment, or state SHALL become DONE if trig_ptr==NUM_TRIG-1 (no wrap).
REQ-023 A PC match on a line already asserted SHALL stall: no fire, no advance; the match is retried each cycle while the PC still matches.
REQ-024 Level mode: irq[k] SHALL stay 1 until a store (|m_data_byteen) with (m_data_addr & ~3) == ACK_BASE+4k, then fall at the next posedge.
REQ-025 Pulse mode: irq[k] SHALL be 1 for exactly PULSE_W cycles via a per-line down-counter; acks on that line SHALL be ignored.
REQ-026 Acks to lines not asserted, or for k ≥ NUM_IRQ, SHALL have no effect.
REQ-027 Ack and fire on the same line in one cycle: fire is blocked (REQ-023); the ack clears it, and the retry fires next cycle if the PC still matches.
REQ-028 Distinct lines SHALL fire and ack independently; at most one fire per cycle.
REQ-029 running SHALL be 1 only in RUN; done SHALL be 1 only in DONE; already-asserted irq lines SHALL complete normally in DONE and IDLE.

Reset
REQ-030 On reset: state=IDLE, trig_ptr=0, irq=0, all counters=0, all entries invalid, running=0, done=0.
REQ-031 Reset asserted mid-pulse or mid-level SHALL drop irq combinationally-asynchronously to 0 without waiting for clk.

Verification
REQ-032 Entries {0x3010,0x3038,0x3054} level line 0, start, PC walks 0x3000 up -> irq[0] rises the cycle after each PC match; each store to 0x7F20 clears it; done=1 after the third fire.
REQ-033 Entry 0 pulse line 2, PULSE_W=4, PC=0x3010 -> irq[2]=1 for exactly 4 cycles; a store to 0x7F28 during the pulse has no effect.
REQ-034 Entries 0 and 1 both line 0 PC 0x3010, level; PC held at 0x3010 -> first fire, stall with trig_ptr=1 until ack to 0x7F20, then irq[0] re-asserts one cycle after the ack clears it.
REQ-035 Entry 1 invalid -> after entry 0 fires, done=1 next cycle, trig_ptr=1, no further irq.
REQ-036 Reset pulsed between clock edges while irq=6'b000101 -> irq=0 immediately; entries invalid; start then gives done=1 next cycle.
REQ-037 Store to 0x7F20 with m_data_byteen=0, or to 0x7F24 while line 1 idle -> no irq change.
